// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash reader: FSM state encoding and flash opcodes.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        WAIT,
        DONE
    } state_t;

    localparam logic [7:0]  OPC_READ      = 8'h03;
    localparam logic [7:0]  OPC_FAST_READ = 8'h0B;
    localparam int unsigned ADDR_BYTES    = 3;

endpackage

// File: rtl/spi_byte_shift.sv
// One 8-bit full-duplex SPI mode-0 transfer: MOSI shifts on SCLK fall, MISO samples on SCLK rise.
module spi_byte_shift
    import spi_flash_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       active,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

    logic          active_q;
    logic          sclk_q;
    logic          done_q;
    logic [CW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            done_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (!active_q) begin
                if (load) begin
                    active_q <= 1'b1;
                    sclk_q   <= 1'b0;
                    div_q    <= '0;
                    bit_q    <= '0;
                    tx_q     <= tx_byte;
                end
            end else if (div_q == DIV_MAX) begin
                div_q <= '0;
                if (!sclk_q) begin
                    sclk_q <= 1'b1;
                    rx_q   <= {rx_q[6:0], miso};
                end else begin
                    // Falling edge: advance MOSI; a zero is shifted in so MOSI idles low.
                    sclk_q <= 1'b0;
                    tx_q   <= {tx_q[6:0], 1'b0};
                    bit_q  <= bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign sclk      = sclk_q;
    assign mosi      = tx_q[7];
    assign active    = active_q;
    assign byte_done = done_q;
    assign rx_byte   = rx_q;

endmodule

// File: rtl/spi_flash_reader.sv
// SPI NOR flash read sequencer (opcode, 24-bit address, optional dummy byte, N data bytes).
// Define SPI_FAST_READ_EN to use FAST READ (0x0B) with one dummy byte.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             spi_cs,
    output logic             spi_clk,
    output logic             spi_dout,
    input  logic             spi_din
);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] OPCODE     = OPC_FAST_READ;
    localparam state_t     AFTER_ADDR = DUMMY;
`else
    localparam logic [7:0] OPCODE     = OPC_READ;
    localparam state_t     AFTER_ADDR = DATA;
`endif

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

    state_t           state_q, state_d;
    logic [23:0]      addr_q;
    logic [LEN_W-1:0] rem_q;
    logic [1:0]       idx_q;
    logic [7:0]       dout_q;
    logic             valid_q;
    logic [CW-1:0]    tail_q;

    logic             sh_load;
    logic [7:0]       sh_tx;
    logic             sh_active;
    logic             sh_done;
    logic [7:0]       sh_rx;

    spi_byte_shift #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .CLK       (CLK),
        .RST       (RST),
        .load      (sh_load),
        .tx_byte   (sh_tx),
        .miso      (spi_din),
        .sclk      (spi_clk),
        .mosi      (spi_dout),
        .active    (sh_active),
        .byte_done (sh_done),
        .rx_byte   (sh_rx)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = (len != '0) ? CMD : DONE;
            CMD:   if (sh_done) state_d = ADDR;
            ADDR:  if (sh_done && idx_q == 2'(ADDR_BYTES - 1)) state_d = AFTER_ADDR;
            DUMMY: if (sh_done) state_d = DATA;
            DATA:  if (sh_done) state_d = WAIT;
            WAIT: begin
                // After the last byte is taken, linger one half-period before releasing CS.
                if (valid_q) begin
                    if (dout_ready && rem_q != '0) state_d = DATA;
                end else if (tail_q == DIV_MAX) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        spi_cs  = (state_q == IDLE) || (state_q == DONE);
        sh_load = 1'b0;
        sh_tx   = 8'h00;
        if (state_q == CMD || state_q == ADDR || state_q == DUMMY || state_q == DATA) begin
            sh_load = !sh_active && !sh_done;
        end
        if (state_q == CMD) begin
            sh_tx = OPCODE;
        end else if (state_q == ADDR) begin
            unique case (idx_q)
                2'd0:    sh_tx = addr_q[23:16];
                2'd1:    sh_tx = addr_q[15:8];
                default: sh_tx = addr_q[7:0];
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            tail_q  <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                addr_q <= addr;
                rem_q  <= len;
                idx_q  <= '0;
            end
            if (state_q == ADDR && sh_done) begin
                idx_q <= idx_q + 2'd1;
            end
            if (state_q == DATA && sh_done) begin
                dout_q  <= sh_rx;
                valid_q <= 1'b1;
                rem_q   <= rem_q - 1'b1;
            end else if (valid_q && dout_ready) begin
                valid_q <= 1'b0;
            end
            if (state_q == WAIT && !valid_q) begin
                tail_q <= tail_q + 1'b1;
            end else begin
                tail_q <= '0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed self-checking bench for spi_flash_reader with a behavioural SPI flash slave.
module tb_spi_flash_reader;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned LEN_W   = 16;

`ifdef SPI_FAST_READ_EN
    localparam int         HDR = 40;
    localparam int         NHB = 5;
    localparam logic [7:0] OPC = 8'h0B;
`else
    localparam int         HDR = 32;
    localparam int         NHB = 4;
    localparam logic [7:0] OPC = 8'h03;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start = 1'b0;
    logic [23:0]      addr = '0;
    logic [LEN_W-1:0] len = '0;
    logic             dout_ready = 1'b0;
    logic             spi_din = 1'b1;
    logic             busy, done, dout_valid, spi_cs, spi_clk, spi_dout;
    logic [7:0]       dout;

    int checks = 0;
    int errors = 0;

    int         rises_total = 0;
    int         bit_pos = 0;
    logic [7:0] mosi_sr = '0;
    logic [7:0] mosi_q[$];
    logic [7:0] rx_q[$];
    int         done_cnt = 0;
    int         vld_cnt = 0;
    logic [7:0] miso_bytes[8];

    always #5 CLK = ~CLK;

    spi_flash_reader #(
        .CLK_DIV (CLK_DIV),
        .LEN_W   (LEN_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .addr       (addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .spi_cs     (spi_cs),
        .spi_clk    (spi_clk),
        .spi_dout   (spi_dout),
        .spi_din    (spi_din)
    );

    function automatic logic miso_bit(input int pos);
        int d;
        d = pos - HDR;
        if (d < 0) return 1'b1;
        return miso_bytes[(d / 8) % 8][7 - (d % 8)];
    endfunction

    // Flash slave: capture MOSI on SCLK rise, present MISO after SCLK fall.
    always @(posedge spi_clk or posedge spi_cs) begin
        if (spi_cs) begin
            bit_pos <= 0;
            mosi_sr <= '0;
        end else begin
            rises_total <= rises_total + 1;
            bit_pos     <= bit_pos + 1;
            mosi_sr     <= {mosi_sr[6:0], spi_dout};
            if (bit_pos % 8 == 7) mosi_q.push_back({mosi_sr[6:0], spi_dout});
        end
    end

    always @(negedge spi_clk or negedge spi_cs) begin
        spi_din <= miso_bit(bit_pos);
    end

    always @(negedge CLK) begin
        if (done) done_cnt <= done_cnt + 1;
        if (dout_valid) vld_cnt <= vld_cnt + 1;
        if (dout_valid && dout_ready) rx_q.push_back(dout);
    end

    task automatic do_start(input logic [23:0] a, input logic [LEN_W-1:0] n);
        @(posedge CLK); #1;
        start = 1'b1;
        addr  = a;
        len   = n;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            if (done_cnt != base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (spi_cs !== 1'b1) begin
            errors++;
            $display("FAIL reset_cs: got %b expected 1", spi_cs);
        end
        checks++;
        if ({spi_clk, spi_dout} !== 2'b00) begin
            errors++;
            $display("FAIL reset_spi: got clk/dout %b expected 00", {spi_clk, spi_dout});
        end
        checks++;
        if ({busy, done, dout_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got busy/done/valid %b expected 000",
                     {busy, done, dout_valid});
        end
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout: got %h expected 00", dout);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_read(input logic [23:0] a, input logic [7:0] d, input string name);
        int         base_d, base_r, base_m, base_x;
        bit         ok;
        logic [7:0] exp_m[5];
        exp_m[0] = OPC;
        exp_m[1] = a[23:16];
        exp_m[2] = a[15:8];
        exp_m[3] = a[7:0];
        exp_m[4] = 8'h00;
        base_d = done_cnt;
        base_r = rises_total;
        base_m = mosi_q.size();
        base_x = rx_q.size();
        miso_bytes[0] = d;
        dout_ready = 1'b1;
        do_start(a, 1);
        wait_done(base_d, ok);
        repeat (5) @(negedge CLK);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 4000 cycles", name);
        end
        checks++;
        if (mosi_q.size() - base_m !== NHB + 1) begin
            errors++;
            $display("FAIL %s_mosi_count: got %0d bytes expected %0d",
                     name, mosi_q.size() - base_m, NHB + 1);
        end else begin
            for (int k = 0; k < NHB; k++) begin
                checks++;
                if (mosi_q[base_m + k] !== exp_m[k]) begin
                    errors++;
                    $display("FAIL %s_mosi%0d: got %h expected %h",
                             name, k, mosi_q[base_m + k], exp_m[k]);
                end
            end
        end
        checks++;
        if (rx_q.size() - base_x !== 1) begin
            errors++;
            $display("FAIL %s_rx_count: got %0d expected 1", name, rx_q.size() - base_x);
        end else begin
            checks++;
            if (rx_q[base_x] !== d) begin
                errors++;
                $display("FAIL %s_dout: got %h expected %h", name, rx_q[base_x], d);
            end
        end
        checks++;
        if (rises_total - base_r !== HDR + 8) begin
            errors++;
            $display("FAIL %s_rises: got %0d expected %0d", name, rises_total - base_r, HDR + 8);
        end
        checks++;
        if (done_cnt - base_d !== 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt - base_d);
        end
        checks++;
        if ({busy, spi_cs} !== 2'b01) begin
            errors++;
            $display("FAIL %s_idle: got busy/cs %b expected 01", name, {busy, spi_cs});
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b[3];
        logic [7:0] held;
        int         base_d, base_r, base_x, bad, n;
        bit         ok;
        exp_b[0] = 8'h01;
        exp_b[1] = 8'h80;
        exp_b[2] = 8'hFF;
        for (int i = 0; i < 3; i++) miso_bytes[i] = exp_b[i];
        base_d = done_cnt;
        base_r = rises_total;
        base_x = rx_q.size();
        dout_ready = 1'b0;
        do_start(24'h000100, 3);
        for (int i = 0; i < 3; i++) begin
            for (n = 0; n < 2000; n++) begin
                @(negedge CLK);
                if (dout_valid) break;
            end
            checks++;
            if (!dout_valid) begin
                errors++;
                $display("FAIL bp_valid%0d: got no dout_valid expected valid within 2000", i);
                break;
            end
            held = dout;
            bad  = 0;
            repeat (20) begin
                @(negedge CLK);
                if (spi_clk !== 1'b0 || dout !== held || dout_valid !== 1'b1) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL bp_stall%0d: got %0d unstable cycles expected 0", i, bad);
            end
            checks++;
            if (held !== exp_b[i]) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h expected %h", i, held, exp_b[i]);
            end
            @(posedge CLK); #1;
            dout_ready = 1'b1;
            @(posedge CLK); #1;
            dout_ready = 1'b0;
        end
        wait_done(base_d, ok);
        repeat (3) @(negedge CLK);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_timeout: got no done expected done within 4000 cycles");
        end
        checks++;
        if (rx_q.size() - base_x !== 3) begin
            errors++;
            $display("FAIL bp_rx_count: got %0d expected 3", rx_q.size() - base_x);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[base_x + i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL bp_order%0d: got %h expected %h", i, rx_q[base_x + i], exp_b[i]);
                end
            end
        end
        checks++;
        if (rises_total - base_r !== HDR + 24) begin
            errors++;
            $display("FAIL bp_rises: got %0d expected %0d", rises_total - base_r, HDR + 24);
        end
    endtask

    task automatic test_len_zero();
        int base_d, base_v, cs_low;
        base_d = done_cnt;
        base_v = vld_cnt;
        cs_low = 0;
        dout_ready = 1'b1;
        do_start(24'h55AA55, 0);
        @(negedge CLK);
        checks++;
        if ({done, spi_cs} !== 2'b11) begin
            errors++;
            $display("FAIL len0_done_pulse: got done/cs %b expected 11", {done, spi_cs});
        end
        repeat (10) begin
            @(negedge CLK);
            if (spi_cs !== 1'b1) cs_low++;
        end
        checks++;
        if (cs_low != 0) begin
            errors++;
            $display("FAIL len0_cs: got %0d low cycles expected 0", cs_low);
        end
        checks++;
        if (vld_cnt - base_v !== 0) begin
            errors++;
            $display("FAIL len0_valid: got %0d valid cycles expected 0", vld_cnt - base_v);
        end
        checks++;
        if (done_cnt - base_d !== 1) begin
            errors++;
            $display("FAIL len0_done_count: got %0d expected 1", done_cnt - base_d);
        end
    endtask

    task automatic test_busy_ignore();
        int  base_d, base_r, base_m, base_x;
        bit  ok;
        base_d = done_cnt;
        base_r = rises_total;
        base_m = mosi_q.size();
        base_x = rx_q.size();
        miso_bytes[0] = 8'h96;
        dout_ready = 1'b1;
        do_start(24'h00ABCD, 1);
        repeat (10) @(negedge CLK);
        do_start(24'hFFFFFF, 5);
        wait_done(base_d, ok);
        repeat (300) @(negedge CLK);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_timeout: got no done expected done within 4000 cycles");
        end
        checks++;
        if (done_cnt - base_d !== 1) begin
            errors++;
            $display("FAIL busy_done_count: got %0d expected 1", done_cnt - base_d);
        end
        checks++;
        if (rises_total - base_r !== HDR + 8) begin
            errors++;
            $display("FAIL busy_rises: got %0d expected %0d", rises_total - base_r, HDR + 8);
        end
        checks++;
        if (mosi_q.size() - base_m !== NHB + 1) begin
            errors++;
            $display("FAIL busy_mosi_count: got %0d expected %0d", mosi_q.size() - base_m, NHB + 1);
        end else begin
            checks++;
            if ({mosi_q[base_m + 1], mosi_q[base_m + 2], mosi_q[base_m + 3]} !== 24'h00ABCD) begin
                errors++;
                $display("FAIL busy_addr: got %h%h%h expected 00abcd", mosi_q[base_m + 1],
                         mosi_q[base_m + 2], mosi_q[base_m + 3]);
            end
        end
        checks++;
        if (rx_q.size() - base_x !== 1) begin
            errors++;
            $display("FAIL busy_rx_count: got %0d expected 1", rx_q.size() - base_x);
        end else begin
            checks++;
            if (rx_q[base_x] !== 8'h96) begin
                errors++;
                $display("FAIL busy_dout: got %h expected 96", rx_q[base_x]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int r0;
        bit hit;
        hit = 1'b0;
        dout_ready = 1'b1;
        do_start(24'hABCDEF, 2);
        for (int n = 0; n < 2000; n++) begin
            @(negedge CLK);
            if (bit_pos >= 12 && spi_clk === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_reach_addr: got no ADDR high phase expected one within 2000");
        end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({spi_cs, spi_clk, busy} !== 3'b100) begin
            errors++;
            $display("FAIL abort_state: got cs/clk/busy %b expected 100", {spi_cs, spi_clk, busy});
        end
        RST = 1'b0;
        r0 = rises_total;
        repeat (50) @(negedge CLK);
        checks++;
        if (rises_total !== r0) begin
            errors++;
            $display("FAIL abort_sclk_quiet: got %0d extra rises expected 0", rises_total - r0);
        end
        test_read(24'h654321, 8'h3C, "after_rst");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) miso_bytes[i] = 8'h00;
        test_reset();
        test_read(24'h123456, 8'hAA, "basic");
`ifdef SPI_FAST_READ_EN
        test_read(24'h000010, 8'h5C, "fast");
`endif
        test_backpressure();
        test_len_zero();
        test_busy_ignore();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, CLK cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter LEN_W, default 16, width of the byte-count input.
REQ-003 SHALL have port CLK  in  1  system clock; the only clock, with all logic on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a read; accepted only while busy=0.
REQ-006 SHALL have port addr  in  24  flash byte address, captured on the accepted start.
REQ-007 SHALL have port len  in  LEN_W  number of bytes to read, captured on the accepted start.
REQ-008 SHALL have port busy  out  1  high from the accepted start until done.
REQ-009 SHALL have port done  out  1  one-cycle pulse when a transaction ends.
REQ-010 SHALL have port dout  out  8  received byte.
REQ-011 SHALL have port dout_valid  out  1  dout holds a valid byte.
REQ-012 SHALL have port dout_ready  in  1  consumer accepts the byte; transfer occurs when valid&&ready.
REQ-013 SHALL have port spi_cs  out  1  chip select, active-low.
REQ-014 SHALL have port spi_clk  out  1  SCLK, SPI mode 0, idles low.
REQ-015 SHALL have port spi_dout  out  1  MOSI.
REQ-016 SHALL have port spi_din  in  1  MISO.

Function
REQ-017 SHALL implement FSM states IDLE, CMD, ADDR, DUMMY, DATA, WAIT, DONE.
REQ-018 IDLE + start + len!=0 SHALL capture addr/len, assert busy, drive spi_cs low on the next cycle, and enter CMD.
REQ-019 IDLE + start + len==0 SHALL leave spi_cs high, pulse done after one cycle, and never assert dout_valid.
REQ-020 SHALL ignore start while busy=1.
REQ-021 CMD SHALL shift opcode 0x03 out MSB-first; ADDR SHALL then shift addr[23:16], addr[15:8], addr[7:0].
REQ-022 SHALL present MOSI at least one half-period before each SCLK rise and change it only while SCLK is low.
REQ-023 SHALL sample MISO on each SCLK rise, MSB-first.
REQ-024 SHALL hold SCLK low for CLK_DIV cycles and high for CLK_DIV cycles, with no extra gap between bits inside a byte.
REQ-025 DATA SHALL, after each 8th rise, wait for the following SCLK low phase, then load dout, assert dout_valid, and decrement the remaining count.
REQ-026 SHALL hold dout stable while dout_valid=1 and dout_ready=0.
REQ-027 WAIT SHALL keep SCLK low until the byte is accepted, so that no byte is ever lost or overwritten.
REQ-028 SHALL begin the next data byte's clocks only after acceptance; if dout_ready=1 in the same cycle valid rises, WAIT SHALL last exactly one cycle.
REQ-029 After the last byte is accepted, spi_cs SHALL go high one half-period later, and DONE SHALL pulse done, clear busy, and return to IDLE.
REQ-030 Total SCLK rises per transaction SHALL be 32 + 8*len, plus 8 when SPI_FAST_READ_EN is defined.
REQ-031 Remaining-byte count SHALL be LEN_W bits wide, with no wrap: len=2^LEN_W-1 reads exactly that many bytes.

Reset
REQ-032 RST SHALL force, on the next CLK edge: state=IDLE, spi_cs=1, spi_clk=0, spi_dout=0, busy=0, done=0, dout_valid=0, dout=0x00.
REQ-033 RST SHALL abort a transaction at any point, including mid-bit with SCLK high, with no further SCLK edges.

Configuration
REQ-034 Macro SPI_FAST_READ_EN defined SHALL select opcode 0x0B with one dummy byte (8 clocks, MOSI=0, MISO ignored) in DUMMY between ADDR and DATA.
REQ-035 Macro SPI_FAST_READ_EN undefined SHALL select opcode 0x03, and DUMMY SHALL be unreachable.

Structure
REQ-036 Package spi_flash_pkg SHALL hold the FSM state enum and the constants OPC_READ=8'h03, OPC_FAST_READ=8'h0B, and ADDR_BYTES=3.
REQ-037 Sub-module spi_byte_shift SHALL perform one 8-bit full-duplex mode-0 transfer (load, shift, byte_done, SCLK divider); spi_flash_reader SHALL sequence it.

Verification
REQ-038 addr=0x123456, len=1, MISO pattern 0xAA, dout_ready=1 -> MOSI bytes 03 12 34 56; dout=0xAA; 40 SCLK rises; done pulses once.
REQ-039 len=3, MISO bytes 0x01 0x80 0xFF, dout_ready held low 20 cycles per byte -> SCLK frozen low during each stall; bytes delivered in order, unchanged.
REQ-040 start with len=0 -> spi_cs stays 1; done pulses; no dout_valid.
REQ-041 RST asserted during the ADDR phase with SCLK high -> next cycle spi_cs=1, spi_clk=0, busy=0; a new start succeeds.
REQ-042 Second start issued while busy -> ignored; exactly one transaction observed.
REQ-043 SPI_FAST_READ_EN defined, addr=0x000010, len=1 -> MOSI bytes 0B 00 00 10 00; 48 SCLK rises; correct dout.
